// File: rtl/dm_sized.sv
// dm_sized: data memory for the MEM stage of the pipelined MIPS datapath.
// Supports byte/half/word stores and sign/zero-extended loads, flags misaligned
// or illegal-size accesses, suppresses their writes and records a sticky fault
// with the address of the first unhandled faulting access.
// Optional feature: define DM_ACCESS_CNT_EN to add the load_cnt/store_cnt
// access counters (and the CNT_W parameter).
module dm_sized #(
    parameter int ADDR_W = 12
`ifdef DM_ACCESS_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    input  logic              we,
    input  logic              re,
    input  logic [1:0]        size,
    input  logic              uns,
    input  logic              fault_clr,
    output logic [31:0]       dout,
    output logic              misalign,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr
`ifdef DM_ACCESS_CNT_EN
    ,
    output logic [CNT_W-1:0]  load_cnt,
    output logic [CNT_W-1:0]  store_cnt
`endif
);

    localparam int WORD_AW = ADDR_W - 2;
    localparam int DEPTH   = 1 << WORD_AW;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    // Address split: word index selects the row, lane selects the byte in it.
    logic [WORD_AW-1:0] word_idx;
    logic [1:0]         lane;
    assign word_idx = addr[ADDR_W-1:2];
    assign lane     = addr[1:0];

    // NOTE: the array is deliberately not reset; it only starts out zeroed,
    // and reset leaves its contents alone so stored data survives a reset.
    logic [31:0] mem_q [DEPTH] = '{default: '0};

    // Store path signals.
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        wr_en;

    // Load path signals.
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Fault register.
    logic              fault_d, fault_q;
    logic [ADDR_W-1:0] fault_addr_d, fault_addr_q;
    logic              new_fault;

    // Misalignment / illegal-size detection, independent of we/re.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        misalign = 1'b0;
        case (size_e'(size))
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = lane[0];
            SZ_WORD: misalign = (lane != 2'b00);
            default: misalign = 1'b1;
        endcase
    end

    // Byte-enable and lane-replicated write data for the store size.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = '0;
        case (size_e'(size))
            SZ_BYTE: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{din[7:0]}};
            end
            SZ_HALF: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{din[15:0]}};
            end
            SZ_WORD: begin
                wr_be   = 4'b1111;
                wr_data = din;
            end
            default: begin
                wr_be   = 4'b0000;
                wr_data = '0;
            end
        endcase
    end

    // A store is committed only when aligned and not held in reset.
    assign wr_en = rst_n & we & ~misalign;

    // Negedge write so a same-cycle read sees the new word by the next posedge.
    always_ff @(negedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) begin
                    // NOTE: clocked state is always updated with <=, so every
                    // reader in the same time step sees the pre-edge value.
                    mem_q[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // Combinational load: lane select then sign/zero extension; zero on fault.
    always_comb begin
        rd_word = mem_q[word_idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = rd_word[{lane[1], 4'b0000} +: 16];
        dout    = '0;
        if (!misalign) begin
            case (size_e'(size))
                SZ_BYTE: dout = {{24{rd_byte[7] & ~uns}}, rd_byte};
                SZ_HALF: dout = {{16{rd_half[15] & ~uns}}, rd_half};
                SZ_WORD: dout = rd_word;
                default: dout = '0;
            endcase
        end
    end

    // Sticky fault next-state: first fault wins unless cleared in the same cycle.
    always_comb begin
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        new_fault    = (we | re) & misalign;
        if (new_fault) begin
            if (!fault_q || fault_clr) begin
                fault_d      = 1'b1;
                fault_addr_d = addr;
            end
        end else if (fault_clr) begin
            fault_d = 1'b0;
        end
    end

    // Fault status register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

`ifdef DM_ACCESS_CNT_EN
    logic [CNT_W-1:0] load_cnt_d, load_cnt_q;
    logic [CNT_W-1:0] store_cnt_d, store_cnt_q;

    // Count non-faulting accesses; both counters may step in the same cycle.
    always_comb begin
        load_cnt_d  = load_cnt_q;
        store_cnt_d = store_cnt_q;
        if (re && !misalign) begin
            load_cnt_d = load_cnt_q + CNT_W'(1);
        end
        if (we && !misalign) begin
            store_cnt_d = store_cnt_q + CNT_W'(1);
        end
    end

    // Access counter registers; wrap naturally and ignore fault_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt_q  <= '0;
            store_cnt_q <= '0;
        end else begin
            load_cnt_q  <= load_cnt_d;
            store_cnt_q <= store_cnt_d;
        end
    end

    assign load_cnt  = load_cnt_q;
    assign store_cnt = store_cnt_q;
`endif

endmodule

// File: tb/tb_dm_sized.sv
// Testbench for dm_sized: directed vector table, same-cycle read/write and
// reset sequences, and randomized traffic against a byte-addressed model.
module tb_dm_sized;

    localparam int ADDR_W = 12;
`ifdef DM_ACCESS_CNT_EN
    localparam int CNT_W = 8;
`endif

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;
    logic              we;
    logic              re;
    logic [1:0]        size;
    logic              uns;
    logic              fault_clr;
    logic [31:0]       dout;
    logic              misalign;
    logic              fault;
    logic [ADDR_W-1:0] fault_addr;
`ifdef DM_ACCESS_CNT_EN
    logic [CNT_W-1:0]  load_cnt;
    logic [CNT_W-1:0]  store_cnt;
`endif

    dm_sized #(
        .ADDR_W(ADDR_W)
`ifdef DM_ACCESS_CNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .din        (din),
        .we         (we),
        .re         (re),
        .size       (size),
        .uns        (uns),
        .fault_clr  (fault_clr),
        .dout       (dout),
        .misalign   (misalign),
        .fault      (fault),
        .fault_addr (fault_addr)
`ifdef DM_ACCESS_CNT_EN
        , .load_cnt (load_cnt)
        , .store_cnt(store_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: byte-addressed memory plus fault/counter state.
    logic [7:0]  m_mem [4096];
    logic        m_fault;
    logic [11:0] m_fa;
    logic [31:0] m_dout;
`ifdef DM_ACCESS_CNT_EN
    logic [CNT_W-1:0] m_ld, m_st;
`endif

    // Values sampled by run_cycle.
    logic [31:0] s_pre, s_dout;
    logic        s_mis, s_fault;
    logic [11:0] s_fa;

    typedef struct {
        logic        we, re;
        logic [1:0]  sz;
        logic        u, clr;
        logic [11:0] a;
        logic [31:0] d;
        logic [31:0] e_dout;
        logic        e_mis, e_fault;
        logic [11:0] e_fa;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic r, input logic [1:0] sz,
                                input logic u, input logic clr, input logic [11:0] a,
                                input logic [31:0] d, input logic [31:0] e_dout,
                                input logic e_mis, input logic e_fault, input logic [11:0] e_fa);
        vec_t v;
        v.we = w; v.re = r; v.sz = sz; v.u = u; v.clr = clr; v.a = a; v.d = d;
        v.e_dout = e_dout; v.e_mis = e_mis; v.e_fault = e_fault; v.e_fa = e_fa;
        return v;
    endfunction

    function automatic logic m_mis(input logic [11:0] a, input logic [1:0] sz);
        int n;
        if (sz == 2'b11) return 1'b1;
        n = 1 << sz;
        return (a % n) != 0;
    endfunction

    function automatic logic [31:0] m_load(input logic [11:0] a, input logic [1:0] sz, input logic u);
        logic [31:0] v;
        int n;
        v = '0;
        if (m_mis(a, sz)) return 32'h0;
        n = 1 << sz;
        for (int i = 0; i < n; i++) v[8*i +: 8] = m_mem[int'(a) + i];
        if (!u && v[8*n-1]) begin
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        end
        return v;
    endfunction

    // One access cycle: drive just after posedge, sample dout after the
    // negedge write, sample status just after the following posedge.
    task automatic run_cycle(input logic w, input logic r, input logic [1:0] sz,
                             input logic u, input logic clr, input logic [11:0] a,
                             input logic [31:0] d);
        logic nf;
        we = w; re = r; size = sz; uns = u; fault_clr = clr; addr = a; din = d;
        #1 s_pre = dout;
        @(negedge clk); #1;
        if (rst_n && w && !m_mis(a, sz)) begin
            for (int i = 0; i < (1 << sz); i++) m_mem[int'(a) + i] = d[8*i +: 8];
        end
        s_dout = dout;
        s_mis  = misalign;
        m_dout = m_load(a, sz, u);
        @(posedge clk); #1;
        if (rst_n) begin
            nf = (w || r) && m_mis(a, sz);
            if (nf && (!m_fault || clr)) begin
                m_fault = 1'b1;
                m_fa    = a;
            end else if (!nf && clr) begin
                m_fault = 1'b0;
            end
`ifdef DM_ACCESS_CNT_EN
            if (r && !m_mis(a, sz)) m_ld = m_ld + 1'b1;
            if (w && !m_mis(a, sz)) m_st = m_st + 1'b1;
`endif
        end
        s_fault = fault;
        s_fa    = fault_addr;
    endtask

    task automatic check_model(input string tag);
        check({tag, " dout"}, s_dout, m_dout);
        check({tag, " misalign"}, s_mis, m_mis(addr, size));
        check({tag, " fault"}, s_fault, m_fault);
        check({tag, " fault_addr"}, s_fa, m_fa);
`ifdef DM_ACCESS_CNT_EN
        check({tag, " load_cnt"}, load_cnt, m_ld);
        check({tag, " store_cnt"}, store_cnt, m_st);
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 4096; i++) m_mem[i] = 8'h00;
        m_fault = 1'b0;
        m_fa    = '0;
`ifdef DM_ACCESS_CNT_EN
        m_ld = '0;
        m_st = '0;
`endif
        rst_n = 1'b0; we = 1'b0; re = 1'b0; size = 2'b10; uns = 1'b0;
        fault_clr = 1'b0; addr = '0; din = '0;

        // Directed vectors: w, r, size, uns, clr, addr, din -> dout, mis, fault, fault_addr
        vecs.push_back(mk(1, 0, 2'b10, 0, 0, 12'h010, 32'h11223344, 32'h11223344, 0, 0, 12'h000));
        vecs.push_back(mk(0, 1, 2'b10, 0, 0, 12'h010, 32'h0,        32'h11223344, 0, 0, 12'h000));
        vecs.push_back(mk(0, 1, 2'b00, 1, 0, 12'h011, 32'h0,        32'h00000033, 0, 0, 12'h000));
        vecs.push_back(mk(0, 1, 2'b00, 0, 0, 12'h013, 32'h0,        32'h00000011, 0, 0, 12'h000));
        vecs.push_back(mk(1, 0, 2'b00, 0, 0, 12'h012, 32'h000000F0, 32'hFFFFFFF0, 0, 0, 12'h000));
        vecs.push_back(mk(0, 1, 2'b10, 0, 0, 12'h010, 32'h0,        32'h11F03344, 0, 0, 12'h000));
        vecs.push_back(mk(0, 1, 2'b00, 0, 0, 12'h012, 32'h0,        32'hFFFFFFF0, 0, 0, 12'h000));
        vecs.push_back(mk(0, 1, 2'b00, 1, 0, 12'h012, 32'h0,        32'h000000F0, 0, 0, 12'h000));
        vecs.push_back(mk(1, 0, 2'b01, 0, 0, 12'h016, 32'h0000ABCD, 32'hFFFFABCD, 0, 0, 12'h000));
        vecs.push_back(mk(0, 1, 2'b10, 0, 0, 12'h014, 32'h0,        32'hABCD0000, 0, 0, 12'h000));
        vecs.push_back(mk(0, 1, 2'b01, 1, 0, 12'h016, 32'h0,        32'h0000ABCD, 0, 0, 12'h000));
        vecs.push_back(mk(1, 0, 2'b10, 0, 0, 12'h021, 32'hDEADBEEF, 32'h00000000, 1, 1, 12'h021));
        vecs.push_back(mk(1, 0, 2'b01, 0, 0, 12'h033, 32'h00001234, 32'h00000000, 1, 1, 12'h021));
        vecs.push_back(mk(0, 1, 2'b10, 0, 0, 12'h020, 32'h0,        32'h00000000, 0, 1, 12'h021));
        vecs.push_back(mk(0, 1, 2'b10, 0, 0, 12'h030, 32'h0,        32'h00000000, 0, 1, 12'h021));
        vecs.push_back(mk(0, 1, 2'b01, 0, 1, 12'h045, 32'h0,        32'h00000000, 1, 1, 12'h045));
        vecs.push_back(mk(0, 0, 2'b10, 0, 1, 12'h000, 32'h0,        32'h00000000, 0, 0, 12'h045));
        vecs.push_back(mk(0, 0, 2'b11, 0, 0, 12'h010, 32'h0,        32'h00000000, 1, 0, 12'h045));
        vecs.push_back(mk(1, 1, 2'b10, 0, 0, 12'h018, 32'h55AA00FF, 32'h55AA00FF, 0, 0, 12'h045));

        // Reset state and zero-initialised memory.
        #2;
        check("reset fault", fault, 1'b0);
        check("reset fault_addr", fault_addr, 12'h000);
        check("init mem dout", dout, 32'h0);
`ifdef DM_ACCESS_CNT_EN
        check("reset load_cnt", load_cnt, '0);
        check("reset store_cnt", store_cnt, '0);
`endif
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            run_cycle(vecs[i].we, vecs[i].re, vecs[i].sz, vecs[i].u, vecs[i].clr, vecs[i].a, vecs[i].d);
            check($sformatf("vec%0d dout", i), s_dout, vecs[i].e_dout);
            check($sformatf("vec%0d misalign", i), s_mis, vecs[i].e_mis);
            check($sformatf("vec%0d fault", i), s_fault, vecs[i].e_fault);
            check($sformatf("vec%0d fault_addr", i), s_fa, vecs[i].e_fa);
        end
`ifdef DM_ACCESS_CNT_EN
        check("table load_cnt", load_cnt, CNT_W'(11));
        check("table store_cnt", store_cnt, CNT_W'(4));
`endif

        // Same-cycle store+load: old word before the negedge, new word after.
        run_cycle(1, 1, 2'b10, 0, 0, 12'h010, 32'h99887766);
        check("rw old before negedge", s_pre, 32'h11F03344);
        check("rw new after negedge", s_dout, 32'h99887766);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            run_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 7) == 0), 12'($urandom_range(0, 255)), $urandom);
            check_model($sformatf("rnd%0d", n));
        end

        // Async reset mid-cycle with a fault set and a store pending.
        run_cycle(1, 0, 2'b10, 0, 0, 12'h040, 32'h01020304);
        run_cycle(1, 0, 2'b10, 0, 0, 12'h0A1, 32'h0);
        check("rst pre fault", s_fault, 1'b1);
        we = 1'b1; re = 1'b1; size = 2'b10; uns = 1'b0; fault_clr = 1'b0;
        addr = 12'h040; din = 32'hCAFEF00D;
        #2 rst_n = 1'b0;
        #1;
        check("rst async fault", fault, 1'b0);
        check("rst async fault_addr", fault_addr, 12'h000);
`ifdef DM_ACCESS_CNT_EN
        check("rst async store_cnt", store_cnt, '0);
        check("rst async load_cnt", load_cnt, '0);
        m_ld = '0;
        m_st = '0;
`endif
        m_fault = 1'b0;
        m_fa    = '0;
        @(negedge clk); #1;
        check("rst write suppressed", dout, 32'h01020304);
        @(posedge clk); #1;
        check("rst held fault", fault, 1'b0);
        we = 1'b0; re = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        run_cycle(0, 1, 2'b10, 0, 0, 12'h040, 32'h0);
        check("rst mem kept", s_dout, 32'h01020304);
        check("rst post fault", s_fault, 1'b0);

`ifdef DM_ACCESS_CNT_EN
        // Store counter wraps after 2^CNT_W stores.
        check("wrap start load_cnt", load_cnt, CNT_W'(1));
        for (int n = 0; n < (1 << CNT_W) - 1; n++) begin
            run_cycle(1, 0, 2'b10, 0, 0, 12'($urandom_range(0, 63) * 4), $urandom);
        end
        check("wrap max store_cnt", store_cnt, {CNT_W{1'b1}});
        run_cycle(1, 0, 2'b10, 0, 0, 12'h100, 32'h0);
        check("wrap zero store_cnt", store_cnt, '0);
        check("wrap load_cnt held", load_cnt, CNT_W'(1));
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
